// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register carrying LANES payload lanes plus an rd index.
// Latency: 1 cycle from acceptance to out_* when empty or draining; optional skid via PIPE_STAGE_SKID_EN.
// Backpressure: out_* held while stalled; default in_ready_o is combinational, skid build registers it.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int LANES  = 3,
    parameter int RD_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [LANES*DATA_W-1:0] in_data_i,
    input  logic [RD_W-1:0]         in_rd_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [LANES*DATA_W-1:0] out_data_o,
    output logic [RD_W-1:0]         out_rd_o,
    output logic [31:0]             stall_cnt_o
);
    localparam int PAY_W = LANES * DATA_W;

    typedef struct packed {
        logic [RD_W-1:0]  rd;
        logic [PAY_W-1:0] dat;
    } entry_t;

    entry_t      in_ent;
    entry_t      main_q, main_d;
    logic        main_vld_q, main_vld_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        accept;
    logic        deliver_slot;
    logic        stalled;

    assign in_ent.rd    = in_rd_i;
    assign in_ent.dat   = in_data_i;
    assign accept       = in_valid_i && in_ready_o;
    // Main register frees up this edge: either empty or its entry is being taken.
    assign deliver_slot = !main_vld_q || out_ready_i;
    assign stalled      = main_vld_q && !out_ready_i && !flush_i;

`ifdef PIPE_STAGE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_vld_q, skid_vld_d;

    assign in_ready_o = !skid_vld_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (deliver_slot) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = in_ent;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_ent;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
`else
    assign in_ready_o = deliver_slot;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
        end else if (accept) begin
            main_d     = in_ent;
            main_vld_d = 1'b1;
        end else if (deliver_slot) begin
            main_vld_d = 1'b0;
        end
    end
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stalled && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q      <= '0;
            main_vld_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            main_q      <= main_d;
            main_vld_q  <= main_vld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q.dat;
    assign out_rd_o    = main_q.rd;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized valid/ready/flush traffic
// checked against a queue-based occupancy model; works for either PIPE_STAGE_SKID_EN build.
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int LN = 3;
    localparam int RW = 5;
    localparam int PW = DW * LN;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [PW-1:0] dat;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [PW-1:0] in_data_i = '0;
    logic [RW-1:0] in_rd_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [PW-1:0] out_data_o;
    logic [RW-1:0] out_rd_o;
    logic [31:0]   stall_cnt_o;

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];
    logic [31:0] m_cnt = '0;

    pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .RD_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .in_rd_i    (in_rd_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_rd_o   (out_rd_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Capacity: skid build holds two entries; plain build can refill only while draining.
    function automatic logic m_ready();
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || out_ready_i;
    endfunction

    task automatic model_edge();
        logic acc, stl;
        ent_t e;
        acc = in_valid_i && m_ready();
        stl = (mq.size() > 0) && !out_ready_i && !flush_i;
        e.rd  = in_rd_i;
        e.dat = in_data_i;
        if (flush_i) begin
            mq.delete();
        end else begin
            if ((mq.size() > 0) && out_ready_i) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        if (stl && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        mq.delete();
        m_cnt = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready_i = 1'b0;
        #1;
        checks++;
        if ({out_valid_o, out_rd_o, out_data_o, stall_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {out_valid_o, out_rd_o, out_data_o, stall_cnt_o});
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready_o);
        end
        do_reset();
        #1;
        checks++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_ready_valid got=%b exp=10", {in_ready_o, out_valid_o});
        end
        @(negedge clk);
    endtask

    task automatic test_streaming();
        ent_t exp;
        do_reset();
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid_i = 1'b1;
            in_rd_i    = RW'(i + 1);
            in_data_i  = {$urandom, $urandom, 32'(32'h1000 + i)};
            exp.rd  = RW'(i + 1);
            exp.dat = in_data_i;
            advance();
            checks++;
            if ({out_valid_o, out_rd_o, out_data_o} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL stream_entry%0d got=%b/%0d/%h exp=1/%0d/%h",
                         i, out_valid_o, out_rd_o, out_data_o, exp.rd, exp.dat);
            end
        end
        in_valid_i = 1'b0;
        advance();
        checks++;
        if ({out_valid_o, stall_cnt_o} !== 33'd0) begin
            errors++;
            $display("FAIL stream_drain got=%b/%0d exp=0/0", out_valid_o, stall_cnt_o);
        end
    endtask

    task automatic test_backpressure();
        ent_t a, b;
        do_reset();
        a.rd = 5'd7;
        a.dat = {$urandom, $urandom, 32'hDEAD_BEEF};
        b.rd = 5'd9;
        b.dat = {$urandom, $urandom, $urandom};
        in_valid_i = 1'b1;
        {in_rd_i, in_data_i} = a;
        advance();
        {in_rd_i, in_data_i} = b;
        for (int k = 1; k <= 5; k++) begin
            advance();
            checks++;
            if ({out_valid_o, out_rd_o, out_data_o, in_ready_o} !== {1'b1, a, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d got=%b/%0d/%h rdy=%b exp=1/%0d/%h rdy=0",
                         k, out_valid_o, out_rd_o, out_data_o, in_ready_o, a.rd, a.dat);
            end
        end
        checks++;
        if (stall_cnt_o !== 32'd5) begin
            errors++;
            $display("FAIL bp_stall_cnt got=%0d exp=5", stall_cnt_o);
        end
        out_ready_i = 1'b1;
        advance();
        in_valid_i = 1'b0;
        checks++;
        if ({out_valid_o, out_rd_o, out_data_o} !== {1'b1, b}) begin
            errors++;
            $display("FAIL bp_release_b got=%b/%0d/%h exp=1/%0d/%h",
                     out_valid_o, out_rd_o, out_data_o, b.rd, b.dat);
        end
        advance();
        checks++;
        if ({out_valid_o, stall_cnt_o} !== {1'b0, 32'd5}) begin
            errors++;
            $display("FAIL bp_drain got=%b/%0d exp=0/5", out_valid_o, stall_cnt_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid_i = 1'b1;
        in_rd_i = 5'd1;
        in_data_i = {$urandom, $urandom, $urandom};
        advance();
        in_rd_i = 5'd2;
        in_data_i = {$urandom, $urandom, $urandom};
        advance();
        flush_i = 1'b1;
        in_rd_i = 5'd3;
        in_data_i = {$urandom, $urandom, $urandom};
        advance();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        checks++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL flush_cleared got=%b/%b exp=0/1", out_valid_o, in_ready_o);
        end
        checks++;
        if (stall_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL flush_stall_cnt got=%0d exp=1", stall_cnt_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        advance();
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped got=%b exp=0", out_valid_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid_i = 1'b1;
        in_rd_i = 5'd4;
        in_data_i = {$urandom, $urandom, $urandom};
        advance();
        in_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) advance();
        checks++;
        if ({out_valid_o, stall_cnt_o} !== {1'b1, 32'd3}) begin
            errors++;
            $display("FAIL areset_pre got=%b/%0d exp=1/3", out_valid_o, stall_cnt_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid_o, out_rd_o, out_data_o, stall_cnt_o, in_ready_o} !== {{(1+RW+PW+32){1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL areset_immediate got=%b/%0d/%h/%0d rdy=%b exp=0/0/0/0 rdy=1",
                     out_valid_o, out_rd_o, out_data_o, stall_cnt_o, in_ready_o);
        end
        mq.delete();
        m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid_i = 1'b1;
        in_rd_i = 5'd11;
        in_data_i = {$urandom, $urandom, $urandom};
        advance();
        in_valid_i = 1'b0;
        checks++;
        if ({out_valid_o, out_rd_o} !== {1'b1, 5'd11}) begin
            errors++;
            $display("FAIL areset_first_accept got=%b/%0d exp=1/11", out_valid_o, out_rd_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid_i = 1'b1;
        in_rd_i = 5'd5;
        in_data_i = {$urandom, $urandom, $urandom};
        advance();
        in_valid_i = 1'b0;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            advance();
            checks++;
            if (stall_cnt_o !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL sat_cycle%0d got=%h exp=ffffffff", k, stall_cnt_o);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            in_valid_i  = ($urandom_range(0, 99) < 70);
            out_ready_i = ($urandom_range(0, 99) < 60);
            flush_i     = ($urandom_range(0, 99) < 2);
            in_rd_i     = RW'($urandom);
            in_data_i   = {$urandom, $urandom, $urandom};
            #1;
            checks++;
            if (in_ready_o !== m_ready()) begin
                errors++;
                $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready_o, m_ready());
            end
            advance();
            checks++;
            if (out_valid_o !== (mq.size() > 0)) begin
                errors++;
                $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, out_valid_o, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                checks++;
                if ({out_rd_o, out_data_o} !== mq[0]) begin
                    errors++;
                    $display("FAIL rand_out_entry cyc=%0d got=%0d/%h exp=%0d/%h",
                             c, out_rd_o, out_data_o, mq[0].rd, mq[0].dat);
                end
            end
            checks++;
            if (stall_cnt_o !== m_cnt) begin
                errors++;
                $display("FAIL rand_stall_cnt cyc=%0d got=%0d exp=%0d", c, stall_cnt_o, m_cnt);
            end
        end
        flush_i = 1'b0;
        in_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one payload lane.
REQ-002 SHALL have parameter LANES, default 3, number of payload lanes (e.g. alu result, read data, pc+4).
REQ-003 SHALL have parameter RD_W, default 5, destination-register index width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  discard all held entries.
REQ-007 SHALL have port in_valid_i  input  1  upstream entry valid.
REQ-008 SHALL have port in_ready_o  output  1  stage can accept an entry.
REQ-009 SHALL have port in_data_i  input  LANES*DATA_W  payload; lane k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port in_rd_i  input  RD_W  destination register index.
REQ-011 SHALL have port out_valid_o  output  1  downstream entry valid.
REQ-012 SHALL have port out_ready_i  input  1  downstream accepts entry.
REQ-013 SHALL have port out_data_o  output  LANES*DATA_W  registered payload.
REQ-014 SHALL have port out_rd_o  output  RD_W  registered destination index.
REQ-015 SHALL have port stall_cnt_o  output  32  saturating count of back-pressured cycles.

Function
REQ-016 SHALL accept an entry on a rising edge where in_valid_i && in_ready_o; SHALL deliver one on an edge where out_valid_o && out_ready_i.
REQ-017 SHALL present an accepted entry on out_* exactly one cycle after acceptance when the stage was empty or draining.
REQ-018 SHALL preserve entry order; no entry duplicated or lost except by flush_i.
REQ-019 SHALL hold out_valid_o, out_data_o, out_rd_o stable while out_valid_o && !out_ready_i.
REQ-020 SHALL, with flush_i high at an edge, clear all valid state and drop any entry offered that cycle; flush_i takes priority over acceptance and delivery.
REQ-021 SHALL increment stall_cnt_o on each edge where out_valid_o && !out_ready_i && !flush_i, saturating at 0xFFFF_FFFF; flush_i does not clear it.
REQ-022 SHALL sustain one transfer per cycle when out_ready_i is held high, with no bubbles.
REQ-023 SHALL leave data registers unchanged (no load) when no entry is accepted.

Reset
REQ-024 SHALL, while rst_n is low, force out_valid_o=0, out_data_o=0, out_rd_o=0, stall_cnt_o=0 and all internal valid/skid state to 0, independent of clk.
REQ-025 SHALL drop any in-flight entry when rst_n asserts mid-transfer; first acceptance possible on the first rising edge after rst_n deasserts.
REQ-026 SHALL drive in_ready_o=1 during and after reset (stage empty).

Configuration
REQ-027 SHALL, with macro PIPE_STAGE_SKID_EN defined, implement a 2-entry skid buffer: main register plus one skid register; in_ready_o is registered and equals !skid_valid; an entry arriving while main is stalled goes to skid; skid moves to main on the next delivery.
REQ-028 SHALL, with PIPE_STAGE_SKID_EN undefined, implement a single register; in_ready_o = !out_valid_o || out_ready_i (combinational); no skid storage.
REQ-029 SHALL, in both builds, meet REQ-016 to REQ-026 identically at the ports except in_ready_o timing per REQ-027/028.

Verification
REQ-030 SHALL cover streaming: out_ready_i=1, inputs lane0=0x1000..0x1007 rd=1..8 on 8 consecutive cycles -> same 8 entries out in order, 1-cycle latency, stall_cnt_o=0.
REQ-031 SHALL cover back-pressure: out_ready_i=0 for 5 cycles with entry A (lane0=0xDEAD_BEEF, rd=7) held -> out_* stable, stall_cnt_o=5; skid build accepts one more entry B then in_ready_o=0; release -> A then B.
REQ-032 SHALL cover flush: two entries held, flush_i=1 with in_valid_i=1 same cycle -> next cycle out_valid_o=0, offered entry dropped, in_ready_o=1.
REQ-033 SHALL cover async reset: rst_n low mid-cycle while out_valid_o=1 and stall_cnt_o=3 -> all outputs 0 immediately, before next clk edge.
REQ-034 SHALL cover saturation: stall_cnt_o forced near 0xFFFF_FFFE, 3 stalled cycles -> stall_cnt_o=0xFFFF_FFFF, no wrap.
REQ-035 SHALL cover random valid/ready toggling for 10k cycles against a FIFO scoreboard in both PIPE_STAGE_SKID_EN builds -> zero mismatches, order preserved.
